// File: rtl/balance_seq.sv
// Lifecycle sequencer for the balance datapath: power-up, rider detect, soft-start ramp,
// steer enable and over-speed fault latch. Optional FAULT support: define BALANCE_SEQ_FAULT_EN.
module balance_seq #(
    parameter int FAST_SIM = 1,
    parameter int SS_DIV   = 1,
    parameter int TF_CNT   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vld,
    input  logic       auth_go,
    input  logic       auth_stop,
    input  logic       rider_off,
    input  logic       too_fast,
    output logic       pwr_up,
    output logic       en_steer,
    output logic [7:0] ss_tmr,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_RIDER = 3'd1,
        SOFT_START = 3'd2,
        BALANCE    = 3'd3,
        FAULT      = 3'd4
    } state_t;

    // The 26-bit settle counter cannot hold 2^26, so its terminal count stands in for it.
    localparam logic [25:0] SETTLE_LIMIT = (FAST_SIM != 0) ? 26'd32768 : 26'h3FF_FFFF;
    localparam logic [3:0]  SS_LAST      = 4'(SS_DIV - 1);
    localparam logic [3:0]  TF_LAST      = 4'(TF_CNT - 1);

    state_t      cur, nxt;
    logic        stop_q, stop_d;
    logic [3:0]  div_q, div_d;
    logic [7:0]  ss_d;
    logic [25:0] settle_q, settle_d;
    logic        run_hit;

`ifdef BALANCE_SEQ_FAULT_EN
    logic [3:0] run_q, run_d;

    // Counts consecutive vld samples that agree with the exit condition of the current state.
    always_comb begin
        run_d   = run_q;
        run_hit = 1'b0;
        if (vld && (cur == BALANCE || cur == FAULT)) begin
            if (too_fast == (cur == BALANCE)) begin
                run_d   = run_q + 4'd1;
                run_hit = (run_q == TF_LAST);
            end else begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= '0;
        end else if (nxt != cur) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end
`else
    logic unused_fault_cfg;
    assign unused_fault_cfg = ^{too_fast, TF_LAST};
    assign run_hit          = 1'b0;
`endif

    always_comb begin
        nxt      = cur;
        stop_d   = stop_q;
        div_d    = div_q;
        ss_d     = ss_tmr;
        settle_d = settle_q;
        case (cur)
            IDLE: begin
                if (auth_go) nxt = WAIT_RIDER;
            end
            WAIT_RIDER: begin
                if (auth_stop || stop_q) nxt = IDLE;
                else if (!rider_off)     nxt = SOFT_START;
            end
            SOFT_START: begin
                if (auth_stop) stop_d = 1'b1;
                if (rider_off) begin
                    nxt = WAIT_RIDER;
                end else if (ss_tmr == 8'hFF) begin
                    nxt = BALANCE;
                end else if (vld) begin
                    if (div_q == SS_LAST) begin
                        div_d = '0;
                        ss_d  = ss_tmr + 8'd1;
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                end
            end
            BALANCE: begin
                if (auth_stop) stop_d = 1'b1;
                if (rider_off)                      nxt = WAIT_RIDER;
                else if (run_hit)                   nxt = FAULT;
                else if (settle_q != SETTLE_LIMIT)  settle_d = settle_q + 26'd1;
            end
            FAULT: begin
                if (auth_stop) stop_d = 1'b1;
                if (rider_off)    nxt = WAIT_RIDER;
                else if (run_hit) nxt = BALANCE;
            end
            default: nxt = IDLE;
        endcase

        // Per-state bookkeeping is cleared whenever the owning state is not the next one.
        if (nxt != SOFT_START)                 div_d    = '0;
        if (nxt == IDLE || nxt == WAIT_RIDER)  ss_d     = '0;
        if (nxt != BALANCE)                    settle_d = '0;
        if (nxt == IDLE)                       stop_d   = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= IDLE;
            stop_q   <= 1'b0;
            div_q    <= '0;
            settle_q <= '0;
            ss_tmr   <= '0;
            pwr_up   <= 1'b0;
            en_steer <= 1'b0;
            fault    <= 1'b0;
        end else begin
            cur      <= nxt;
            stop_q   <= stop_d;
            div_q    <= div_d;
            settle_q <= settle_d;
            ss_tmr   <= ss_d;
            pwr_up   <= (nxt != IDLE);
            en_steer <= (nxt == BALANCE) && (settle_d == SETTLE_LIMIT);
            fault    <= (nxt == FAULT);
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_balance_seq.sv
// Self-checking bench for balance_seq: vector table for the lifecycle, hand sequences for
// ramp, settle, reset and fault corners. Fault checks follow BALANCE_SEQ_FAULT_EN.
module tb_balance_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld = 1'b0;
    logic       auth_go = 1'b0;
    logic       auth_stop = 1'b0;
    logic       rider_off = 1'b1;
    logic       too_fast = 1'b0;
    logic       pwr_up, en_steer, fault;
    logic [7:0] ss_tmr;
    logic [2:0] state;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [2:0] st;
        logic       pwr;
        logic       steer;
        logic [7:0] ss;
        logic       flt;
    } exp_t;

    typedef struct {
        logic       v, go, stop, roff, tf;
        logic [2:0] st;
        logic       pwr, steer;
        logic [7:0] ss;
        logic       flt;
    } vec_t;

    exp_t  sb_q[$];
    string tag_q[$];
    vec_t  vecs[18];

    balance_seq #(.FAST_SIM(1), .SS_DIV(1), .TF_CNT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .auth_go   (auth_go),
        .auth_stop (auth_stop),
        .rider_off (rider_off),
        .too_fast  (too_fast),
        .pwr_up    (pwr_up),
        .en_steer  (en_steer),
        .ss_tmr    (ss_tmr),
        .fault     (fault),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic pushExpect(input logic [2:0] st, input logic pwr, steer,
                              input logic [7:0] ss, input logic flt, input string tag);
        exp_t e;
        e.st = st; e.pwr = pwr; e.steer = steer; e.ss = ss; e.flt = flt;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput();
        exp_t  e;
        string tag;
        checks++;
        if (sb_q.size() == 0) begin
            $display("[TB] FAIL scoreboard: got empty queue, required a pending expectation");
            return;
        end
        e   = sb_q.pop_front();
        tag = tag_q.pop_front();
        if (state === e.st && pwr_up === e.pwr && en_steer === e.steer &&
            ss_tmr === e.ss && fault === e.flt) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got state=%0d pwr_up=%0b en_steer=%0b ss_tmr=%0d fault=%0b, required state=%0d pwr_up=%0b en_steer=%0b ss_tmr=%0d fault=%0b",
                     tag, state, pwr_up, en_steer, ss_tmr, fault, e.st, e.pwr, e.steer, e.ss, e.flt);
        end
    endtask

    // Drives one cycle of inputs, lets one rising edge pass, then clears the pulse inputs.
    task automatic applyStimulus(input logic v, go, stop, roff, tf);
        vld = v; auth_go = go; auth_stop = stop; rider_off = roff; too_fast = tf;
        @(posedge clk);
        #1;
        vld = 1'b0; auth_go = 1'b0; auth_stop = 1'b0;
    endtask

    task automatic step(input logic v, go, stop, roff, tf,
                        input logic [2:0] st, input logic pwr, steer,
                        input logic [7:0] ss, input logic flt, input string tag);
        pushExpect(st, pwr, steer, ss, flt, tag);
        applyStimulus(v, go, stop, roff, tf);
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, too_fast);
    endtask

    // From SOFT_START with ss_tmr=0: 255 vld pulses, then one more clock into BALANCE.
    task automatic rampToBalance(input string tag);
        for (int i = 0; i < 255; i++)
            step(1, 0, 0, 0, 0, 3'd2, 1, 0, 8'(i + 1), 0, tag);
        step(0, 0, 0, 0, 0, 3'd3, 1, 0, 8'd255, 0, {tag, "_enter_balance"});
    endtask

    function automatic vec_t mk(input logic v, go, stop, roff, input logic [2:0] st,
                                input logic pwr, input logic [7:0] ss);
        vec_t r;
        r.v = v; r.go = go; r.stop = stop; r.roff = roff; r.tf = 1'b0;
        r.st = st; r.pwr = pwr; r.steer = 1'b0; r.ss = ss; r.flt = 1'b0;
        return r;
    endfunction

    initial begin
        vecs[0]  = mk(0, 0, 0, 1, 3'd0, 0, 8'd0);
        vecs[1]  = mk(0, 0, 1, 1, 3'd0, 0, 8'd0);
        vecs[2]  = mk(0, 1, 0, 1, 3'd1, 1, 8'd0);
        vecs[3]  = mk(0, 1, 0, 1, 3'd1, 1, 8'd0);
        vecs[4]  = mk(0, 0, 1, 1, 3'd0, 0, 8'd0);
        vecs[5]  = mk(0, 1, 0, 1, 3'd1, 1, 8'd0);
        vecs[6]  = mk(0, 0, 0, 0, 3'd2, 1, 8'd0);
        vecs[7]  = mk(1, 0, 0, 0, 3'd2, 1, 8'd1);
        vecs[8]  = mk(0, 0, 0, 0, 3'd2, 1, 8'd1);
        vecs[9]  = mk(1, 0, 0, 0, 3'd2, 1, 8'd2);
        vecs[10] = mk(1, 0, 0, 1, 3'd1, 1, 8'd0);
        vecs[11] = mk(0, 0, 0, 0, 3'd2, 1, 8'd0);
        vecs[12] = mk(1, 0, 1, 0, 3'd2, 1, 8'd1);
        vecs[13] = mk(0, 0, 0, 1, 3'd1, 1, 8'd0);
        vecs[14] = mk(0, 0, 0, 1, 3'd0, 0, 8'd0);
        vecs[15] = mk(0, 1, 0, 1, 3'd1, 1, 8'd0);
        vecs[16] = mk(0, 0, 0, 1, 3'd1, 1, 8'd0);
        vecs[17] = mk(0, 0, 0, 0, 3'd2, 1, 8'd0);

        #2;
        pushExpect(3'd0, 0, 0, 8'd0, 0, "reset_values");
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 18; i++)
            step(vecs[i].v, vecs[i].go, vecs[i].stop, vecs[i].roff, vecs[i].tf,
                 vecs[i].st, vecs[i].pwr, vecs[i].steer, vecs[i].ss, vecs[i].flt,
                 $sformatf("vec%0d", i));

        for (int i = 0; i < 100; i++)
            step(1, 0, 0, 0, 0, 3'd2, 1, 0, 8'(i + 1), 0, "ramp_to_100");
        step(1, 0, 0, 1, 0, 3'd1, 1, 0, 8'd0, 0, "vld_with_rider_off");
        step(0, 0, 0, 0, 0, 3'd2, 1, 0, 8'd0, 0, "restart_soft_start");

        rampToBalance("ramp1");
        idleCycles(32766);
        step(0, 0, 0, 0, 0, 3'd3, 1, 0, 8'd255, 0, "steer_not_yet");
        step(0, 0, 0, 0, 0, 3'd3, 1, 1, 8'd255, 0, "steer_on");
        step(0, 0, 0, 0, 0, 3'd3, 1, 1, 8'd255, 0, "steer_hold");

        // Asynchronous reset in the middle of a cycle, well away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        pushExpect(3'd0, 0, 0, 8'd0, 0, "async_reset");
        checkOutput();
        @(posedge clk);
        #1;
        pushExpect(3'd0, 0, 0, 8'd0, 0, "reset_held");
        checkOutput();
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 3'd0, 0, 0, 8'd0, 0, "idle_after_reset");
        step(0, 1, 0, 0, 0, 3'd1, 1, 0, 8'd0, 0, "go_after_reset");
        step(0, 0, 0, 0, 0, 3'd2, 1, 0, 8'd0, 0, "soft_start_2");
        rampToBalance("ramp2");
        idleCycles(32767);
        step(0, 0, 0, 0, 0, 3'd3, 1, 1, 8'd255, 0, "steer_on_2");

        step(0, 0, 1, 0, 0, 3'd3, 1, 1, 8'd255, 0, "stop_in_balance");

`ifdef BALANCE_SEQ_FAULT_EN
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 1, 3'd3, 1, 1, 8'd255, 0, "tf_run3");
        step(1, 0, 0, 0, 0, 3'd3, 1, 1, 8'd255, 0, "tf_run_broken");
        step(0, 0, 0, 0, 1, 3'd3, 1, 1, 8'd255, 0, "tf_no_vld");
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 1, 3'd3, 1, 1, 8'd255, 0, "tf_run4_pre");
        step(1, 0, 0, 0, 1, 3'd4, 1, 0, 8'd255, 1, "fault_enter");
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 3'd4, 1, 0, 8'd255, 1, "fault_hold");
        step(1, 0, 0, 0, 0, 3'd3, 1, 0, 8'd255, 0, "fault_exit");
        step(0, 0, 0, 0, 0, 3'd3, 1, 0, 8'd255, 0, "settle_cleared");
`else
        for (int i = 0; i < 20; i++)
            step(1, 0, 0, 0, 1, 3'd3, 1, 1, 8'd255, 0, "tf_ignored");
`endif

        step(0, 0, 0, 1, 0, 3'd1, 1, 0, 8'd0, 0, "rider_off_balance");
        step(0, 0, 0, 1, 0, 3'd0, 0, 0, 8'd0, 0, "stop_pend_to_idle");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
